tim_apb_master: RTL

APB4 initiator that drives the timer's APB slave port from a simple valid/ready command interface.
- Used by the on-chip test sequencer and the CPU-less bring-up path to program and poll timer registers (TCR, TDR0/1, TCMP0/1, TIER, TISR, THCSR).
- One outstanding transfer at a time.
- Response, including PSLVERR, is returned on a valid/ready response channel.

---
 rtl/tim_apb_pkg.sv | 24 ++
 rtl/tim_apb_master_if.sv | 51 +++++
 rtl/tim_apb_wdog.sv | 29 ++
 rtl/tim_apb_master.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/tim_apb_pkg.sv
// Shared definitions for the timer APB initiator: FSM encoding, bus width
// defaults and the timer register map.
package tim_apb_pkg;

  localparam int unsigned TIM_ADDR_W = 12;
  localparam int unsigned TIM_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam logic [TIM_ADDR_W-1:0] TIM_TCR   = 12'h000;
  localparam logic [TIM_ADDR_W-1:0] TIM_TDR0  = 12'h004;
  localparam logic [TIM_ADDR_W-1:0] TIM_TDR1  = 12'h008;
  localparam logic [TIM_ADDR_W-1:0] TIM_TCMP0 = 12'h00C;
  localparam logic [TIM_ADDR_W-1:0] TIM_TCMP1 = 12'h010;
  localparam logic [TIM_ADDR_W-1:0] TIM_TIER  = 12'h014;
  localparam logic [TIM_ADDR_W-1:0] TIM_TISR  = 12'h018;
  localparam logic [TIM_ADDR_W-1:0] TIM_THCSR = 12'h01C;

endpackage

// File: rtl/tim_apb_master_if.sv
// Command/response channel plus the APB4 bus towards the timer slave.
// master modport is the initiator's view; slave modport is the environment's.
interface tim_apb_master_if
  import tim_apb_pkg::*;
#(
  parameter int unsigned ADDR_W = TIM_ADDR_W,
  parameter int unsigned DATA_W = TIM_DATA_W
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_write;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic [DATA_W/8-1:0] cmd_strb;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;
  logic                rsp_timeout;

  logic                tim_psel;
  logic                tim_penable;
  logic                tim_pwrite;
  logic [ADDR_W-1:0]   tim_paddr;
  logic [DATA_W-1:0]   tim_pwdata;
  logic [DATA_W/8-1:0] tim_pstrb;
  logic                tim_pready;
  logic [DATA_W-1:0]   tim_prdata;
  logic                tim_pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
    input  tim_pready, tim_prdata, tim_pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
    output tim_pready, tim_prdata, tim_pslverr
  );

endinterface

// File: rtl/tim_apb_wdog.sv
// ACCESS-phase watchdog: counts stalled cycles and flags when LIMIT-1 is reached.
// Only instantiated when TIM_APB_MASTER_TIMEOUT_EN is defined.
module tim_apb_wdog #(
  parameter int unsigned LIMIT = 256
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(LIMIT) + 1;

  logic [CNT_W-1:0] cnt_q;

  assign expired = (cnt_q == CNT_W'(LIMIT - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (inc && !expired) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tim_apb_master.sv
// APB4 initiator for the timer register block, driven by a valid/ready command
// channel. Optional ACCESS timeout: define TIM_APB_MASTER_TIMEOUT_EN.
module tim_apb_master
  import tim_apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = TIM_ADDR_W,
  parameter int unsigned DATA_W         = TIM_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  tim_apb_master_if.master bus
);

  localparam int unsigned STRB_W = DATA_W / 8;

  apb_state_e        state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0] pstrb_q, pstrb_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

`ifdef TIM_APB_MASTER_TIMEOUT_EN
  logic rsp_timeout_q, rsp_timeout_d;
  logic wdog_expired;

  // Counter is held clear outside ACCESS, so it restarts from zero on each entry.
  tim_apb_wdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clear     (state_q != ST_ACCESS),
    .inc       ((state_q == ST_ACCESS) && !bus.tim_pready),
    .expired   (wdog_expired)
  );

  assign bus.rsp_timeout = rsp_timeout_q;
`else
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end

  assign bus.rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef TIM_APB_MASTER_TIMEOUT_EN
    rsp_timeout_d = rsp_timeout_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          pwrite_d    = bus.cmd_write;
          paddr_d     = bus.cmd_addr;
          pwdata_d    = bus.cmd_write ? bus.cmd_wdata : '0;
          pstrb_d     = bus.cmd_write ? bus.cmd_strb  : '0;
          psel_d      = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (bus.tim_pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : bus.tim_prdata;
          rsp_err_d   = bus.tim_pslverr;
`ifdef TIM_APB_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
          state_d     = ST_RESP;
        end
`ifdef TIM_APB_MASTER_TIMEOUT_EN
        else if (wdog_expired) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end
`endif
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef TIM_APB_MASTER_TIMEOUT_EN
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef TIM_APB_MASTER_TIMEOUT_EN
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.tim_psel    = psel_q;
  assign bus.tim_penable = penable_q;
  assign bus.tim_pwrite  = pwrite_q;
  assign bus.tim_paddr   = paddr_q;
  assign bus.tim_pwdata  = pwdata_q;
  assign bus.tim_pstrb   = pstrb_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;

endmodule
